dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Shares the single data-memory port between two requesters: the pipeline MEM stage (core port) and an auxiliary master (debug loader / DMA, aux port).
- Core has fixed priority. A starvation guard gives aux one guaranteed slot after MAX_WAIT consecutive losses.
- Tracks in-flight reads so each read response is routed back to its issuer after the fixed memory latency.
- Sits between the memory-stage logic and the DMEM interface. Drives a stall to the pipeline when the core loses arbitration.

Parameters:
- RD_LATENCY, 1, cycles from read issue on DMEM to valid DMEM_data_i; legal range 1..4.
- MAX_WAIT, 8, consecutive aux-denied cycles before aux is forced through; 0 disables the guard (strict core priority).

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- core_req_i  in  1  core access request
- core_we_i  in  1  1=write, 0=read
- core_addr_i  in  32  core byte address
- core_wdata_i  in  32  core write data
- core_gnt_o  out  1  core access issued this cycle
- core_stall_o  out  1  core_req_i & ~core_gnt_o
- core_rvalid_o  out  1  core read data valid
- core_rdata_o  out  32  core read data
- aux_req_i  in  1  aux access request
- aux_we_i  in  1  1=write, 0=read
- aux_addr_i  in  32  aux byte address
- aux_wdata_i  in  32  aux write data
- aux_gnt_o  out  1  aux access issued this cycle
- aux_rvalid_o  out  1  aux read data valid
- aux_rdata_o  out  32  aux read data
- DMEM_addr_o  out  32  memory address
- DMEM_data_o  out  32  memory write data
- DMEM_read_o  out  1  memory read strobe
- DMEM_write_o  out  1  memory write strobe
- DMEM_data_i  in  32  memory read data

Behaviour:
- Grant is combinational, same cycle as request. At most one grant per cycle. A request holds its fields stable until granted.
- Arbitration:
  - force_aux = (MAX_WAIT!=0) & aux_req_i & (wait_cnt==MAX_WAIT).
  - aux_gnt = aux_req_i & (~core_req_i | force_aux).
  - core_gnt = core_req_i & ~aux_gnt.
- wait_cnt (width $clog2(MAX_WAIT+1)):
  - Increments on cycles with aux_req_i=1 and aux_gnt=0, saturating at MAX_WAIT.
  - Clears on aux_gnt or when aux_req_i=0.
- DMEM mux:
  - Granted port drives addr/data.
  - DMEM_read_o = gnt & ~we; DMEM_write_o = gnt & we.
  - With no grant: read=write=0, addr/data follow the core port (no stray strobes).
- Read tracking:
  - Shift register of RD_LATENCY entries {valid, owner}. Stage 0 is loaded each cycle with the issued read (valid=0 for writes/idle).
  - Output stage drives core_rvalid_o / aux_rvalid_o (one-hot or none).
  - core_rdata_o = aux_rdata_o = DMEM_data_i, unregistered; valid only with the matching rvalid.
- Writes produce no response.
- Back-to-back reads from either or alternating owners are supported every cycle; responses return in issue order.
- Reset (synchronous, reset_n=0):
  - wait_cnt=0, all tracking entries invalid.
  - rvalid outputs 0 from the cycle after reset is sampled. Reads in flight at reset are dropped, never delivered.
  - gnt/stall/DMEM strobes stay combinational from the request inputs; the environment holds requests low during reset.
- Latency: read issued in cycle N → rvalid in cycle N+RD_LATENCY.

Decomposition:
- Shared package dmem_pkg:
  - owner encoding constants OWNER_CORE=0, OWNER_AUX=1.
  - tracking-entry typedef {valid, owner}.
- Optional sub-module: rd_tag_pipe (parameterised RD_LATENCY shift register of tracking entries with synchronous clear). Arbitration and counter stay in the top.

Test Plan:
- Core-only read addr 0x100, RD_LATENCY=1 → core_gnt_o=1, DMEM_read_o=1 same cycle; core_rvalid_o=1 next cycle with memory word; aux_rvalid_o=0.
- Core and aux both request continuously, MAX_WAIT=8 → core granted 8 cycles, stall=0; aux granted on 9th cycle with core_stall_o=1; pattern repeats every 9 cycles.
- MAX_WAIT=0, both requesting 20 cycles → aux never granted, wait_cnt unused.
- Alternating reads core 0x10 / aux 0x20 / core 0x30 with RD_LATENCY=3 → rvalid sequence core, aux, core starting 3 cycles after first issue, data matching each address.
- Aux write 0xDEADBEEF to 0x40, then core read 0x40 → DMEM_write_o pulse, no rvalid for write; core reads 0xDEADBEEF.
- Core read issued, reset_n=0 on next cycle (RD_LATENCY=2) → no rvalid ever appears for that read; wait_cnt=0 after reset.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter slice.
//   OWNER_CORE / OWNER_AUX : encoding of which requester issued a read
//   rd_tag_t               : one in-flight read tracking entry {valid, owner}
package dmem_pkg;

  localparam logic OWNER_CORE = 1'b0;
  localparam logic OWNER_AUX  = 1'b1;

  typedef struct packed {
    logic valid;
    logic owner;
  } rd_tag_t;

endpackage

// File: rtl/rd_tag_pipe.sv
// Fixed-length delay line of read tracking entries. An entry loaded on tag_in
// appears on tag_out DEPTH cycles later, matching the memory read latency.
// Ports:
//   clk      : clock
//   reset_n  : synchronous active-low clear, invalidates every entry
//   tag_in   : entry for the access issued this cycle
//   tag_out  : entry whose read data is on the memory bus this cycle
module rd_tag_pipe
  import dmem_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic    clk,
  input  logic    reset_n,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out
);

  rd_tag_t stage_reg [DEPTH];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      // Dropping everything here is what discards reads in flight at reset.
      for (int i = 0; i < DEPTH; i++) stage_reg[i] <= '0;
    end else begin
      stage_reg[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) stage_reg[i] <= stage_reg[i-1];
    end
  end

  assign tag_out = stage_reg[DEPTH-1];

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single data-memory port.
// Core has fixed priority; aux is forced through after MAX_WAIT consecutive
// denied cycles (MAX_WAIT=0 keeps strict core priority). Reads are tagged
// with their issuer and the response is steered back RD_LATENCY cycles later.
// Ports:
//   clk, reset_n            : clock, synchronous active-low reset
//   core_* / aux_*          : requester sides (req/we/addr/wdata in,
//                             gnt/rvalid/rdata out, core also gets stall)
//   DMEM_*                  : memory port (addr/data/read/write out, data in)
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int RD_LATENCY = 1,
  parameter int MAX_WAIT   = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wdata_i,
  output logic        core_gnt_o,
  output logic        core_stall_o,
  output logic        core_rvalid_o,
  output logic [31:0] core_rdata_o,
  input  logic        aux_req_i,
  input  logic        aux_we_i,
  input  logic [31:0] aux_addr_i,
  input  logic [31:0] aux_wdata_i,
  output logic        aux_gnt_o,
  output logic        aux_rvalid_o,
  output logic [31:0] aux_rdata_o,
  output logic [31:0] DMEM_addr_o,
  output logic [31:0] DMEM_data_o,
  output logic        DMEM_read_o,
  output logic        DMEM_write_o,
  input  logic [31:0] DMEM_data_i
);

  // At least one bit so the counter stays declarable when the guard is off.
  localparam int              CNT_W      = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] wait_cnt_reg;
  logic [CNT_W-1:0] wait_cnt_next;
  logic             force_aux;
  logic             aux_gnt;
  logic             core_gnt;
  logic             any_gnt;
  logic             gnt_we;
  rd_tag_t          tag_issue;
  rd_tag_t          tag_ret;

  // Arbitration
  assign force_aux = (MAX_WAIT != 0) && aux_req_i && (wait_cnt_reg == WAIT_LIMIT);
  assign aux_gnt   = aux_req_i && (!core_req_i || force_aux);
  assign core_gnt  = core_req_i && !aux_gnt;
  assign any_gnt   = core_gnt || aux_gnt;

  assign core_gnt_o   = core_gnt;
  assign aux_gnt_o    = aux_gnt;
  assign core_stall_o = core_req_i && !core_gnt;

  // Consecutive-loss counter; any break in the aux request or a grant restarts it.
  always_comb begin
    wait_cnt_next = '0;
    if (aux_req_i && !aux_gnt) begin
      wait_cnt_next = (wait_cnt_reg == WAIT_LIMIT) ? wait_cnt_reg : wait_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) wait_cnt_reg <= '0;
    else          wait_cnt_reg <= wait_cnt_next;
  end

  // Memory port mux; idle cycles show the core fields with both strobes low.
  assign gnt_we       = aux_gnt ? aux_we_i    : core_we_i;
  assign DMEM_addr_o  = aux_gnt ? aux_addr_i  : core_addr_i;
  assign DMEM_data_o  = aux_gnt ? aux_wdata_i : core_wdata_i;
  assign DMEM_read_o  = any_gnt && !gnt_we;
  assign DMEM_write_o = any_gnt && gnt_we;

  // Read return routing
  assign tag_issue.valid = DMEM_read_o;
  assign tag_issue.owner = aux_gnt ? OWNER_AUX : OWNER_CORE;

  rd_tag_pipe #(
    .DEPTH (RD_LATENCY)
  ) u_rd_tag_pipe (
    .clk     (clk),
    .reset_n (reset_n),
    .tag_in  (tag_issue),
    .tag_out (tag_ret)
  );

  assign core_rvalid_o = tag_ret.valid && (tag_ret.owner == OWNER_CORE);
  assign aux_rvalid_o  = tag_ret.valid && (tag_ret.owner == OWNER_AUX);
  assign core_rdata_o  = DMEM_data_i;
  assign aux_rdata_o   = DMEM_data_i;

endmodule
